// File: rtl/pll_reset_sequencer_pkg.sv
// pll_reset_sequencer_pkg: shared types and constants for the PLL reset sequencer.
//   state_e      : sequencer FSM states
//   RELOCK_W     : width of the relock counter output
//   max_u()      : helper used to size shared counters from parameters
package pll_reset_sequencer_pkg;

  localparam int unsigned RELOCK_W = 8;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: PLL-side and domain-reset signals of the sequencer.
//   pll_locked  : lock indicator from the PLL (asynchronous)
//   pll_rst     : reset to the PLL primitive
//   domain_rst  : per-output-domain resets, bit i for CLK_OUT(i+1)
//   ready       : all domains released and PLL locked
//   relock_cnt  : saturating count of lock losses
//   timeout_err : sticky lock watchdog flag
// master = sequencer side, slave = PLL wrapper / consumers side.
interface pll_reset_sequencer_if #(
  parameter int unsigned N_OUT = 4
);
  import pll_reset_sequencer_pkg::*;

  logic                pll_locked;
  logic                pll_rst;
  logic [N_OUT-1:0]    domain_rst;
  logic                ready;
  logic [RELOCK_W-1:0] relock_cnt;
  logic                timeout_err;

  modport master (
    input  pll_locked,
    output pll_rst, domain_rst, ready, relock_cnt, timeout_err
  );

  modport slave (
    output pll_locked,
    input  pll_rst, domain_rst, ready, relock_cnt, timeout_err
  );

endinterface

// File: rtl/pll_reset_sequencer_lock_sync.sv
// lock_sync: two-flop synchronizer for a slow asynchronous level (e.g. PLL lock).
//   clk : destination clock
//   rst : synchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : synchronized output, 2 cycles of latency
module lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta;
  (* ASYNC_REG = "TRUE" *) logic sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the per-domain resets one at a time; any lock loss restarts it.
//   clk_in1 : free-running reference clock (only clock of the block)
//   rst     : synchronous active-high reset
//   pll_if  : master modport of pll_reset_sequencer_if (lock in, resets/status out)
// Optional feature macro PLL_SEQ_WATCHDOG_EN: enables the WAIT_LOCK timeout
// and the sticky timeout_err flag; otherwise WAIT_LOCK waits indefinitely.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned N_OUT          = 4
) (
  input logic                  clk_in1,
  input logic                  rst,
  pll_reset_sequencer_if.master pll_if
);
  import pll_reset_sequencer_pkg::*;

  // One shared counter covers every timed phase, so it spans the largest limit.
  localparam int unsigned CNT_MAX = max_u(max_u(RST_CYCLES, STABLE_CYCLES),
                                          max_u(STAGGER_CYCLES, LOCK_TIMEOUT));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e              state_q, state_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic                pll_rst_q, pll_rst_nxt;
  logic [N_OUT-1:0]    domain_rst_q, domain_rst_nxt;
  logic                ready_q, ready_nxt;
  logic [RELOCK_W-1:0] relock_q, relock_nxt;
  logic                timeout_q, timeout_nxt;
  logic                lock_s;

  lock_sync u_lock_sync (
    .clk (clk_in1),
    .rst (rst),
    .d   (pll_if.pll_locked),
    .q   (lock_s)
  );

  // State and registered outputs.
  always_ff @(posedge clk_in1) begin
    if (rst) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= '1;
      ready_q      <= 1'b0;
      relock_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      pll_rst_q    <= pll_rst_nxt;
      domain_rst_q <= domain_rst_nxt;
      ready_q      <= ready_nxt;
      relock_q     <= relock_nxt;
      timeout_q    <= timeout_nxt;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_nxt      = state_q;
    cnt_nxt        = cnt_q;
    pll_rst_nxt    = 1'b0;
    domain_rst_nxt = domain_rst_q;
    ready_nxt      = 1'b0;
    relock_nxt     = relock_q;
    timeout_nxt    = timeout_q;

    case (state_q)
      ST_RESET: begin
        pll_rst_nxt    = 1'b1;
        domain_rst_nxt = '1;
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_nxt   = ST_WAIT_LOCK;
          cnt_nxt     = '0;
          pll_rst_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        // Lock is checked first so it wins over a same-cycle timeout.
        if (lock_s) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = CNT_W'(1);
        end
`ifdef PLL_SEQ_WATCHDOG_EN
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_nxt      = ST_RESET;
          cnt_nxt        = '0;
          pll_rst_nxt    = 1'b1;
          domain_rst_nxt = '1;
          timeout_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
`else
        else begin
          cnt_nxt = '0;
        end
`endif
      end

      ST_STABLE: begin
        // cnt already includes the lock cycle that caused entry.
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES)) begin
          state_nxt      = ST_RELEASE;
          cnt_nxt        = '0;
          domain_rst_nxt = domain_rst_q << 1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        // Left shift clears the next-higher domain bit each stagger period.
        if (!lock_s) begin
          state_nxt      = ST_RESET;
          cnt_nxt        = '0;
          pll_rst_nxt    = 1'b1;
          domain_rst_nxt = '1;
          if (relock_q != '1) relock_nxt = relock_q + RELOCK_W'(1);
        end else if (domain_rst_q == '0) begin
          state_nxt = ST_RUN;
          ready_nxt = 1'b1;
        end else if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
          cnt_nxt        = '0;
          domain_rst_nxt = domain_rst_q << 1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (!lock_s) begin
          state_nxt      = ST_RESET;
          cnt_nxt        = '0;
          pll_rst_nxt    = 1'b1;
          domain_rst_nxt = '1;
          if (relock_q != '1) relock_nxt = relock_q + RELOCK_W'(1);
        end else begin
          ready_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt      = ST_RESET;
        cnt_nxt        = '0;
        pll_rst_nxt    = 1'b1;
        domain_rst_nxt = '1;
      end
    endcase
  end

  assign pll_if.pll_rst     = pll_rst_q;
  assign pll_if.domain_rst  = domain_rst_q;
  assign pll_if.ready       = ready_q;
  assign pll_if.relock_cnt  = relock_q;
  assign pll_if.timeout_err = timeout_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed self-checking bench for pll_reset_sequencer
// with RST_CYCLES=4, STABLE_CYCLES=8, STAGGER_CYCLES=2, LOCK_TIMEOUT=32.
module tb_pll_reset_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pll_reset_sequencer_if #(.N_OUT(4)) bus ();

  pll_reset_sequencer #(
    .RST_CYCLES     (4),
    .STABLE_CYCLES  (8),
    .STAGGER_CYCLES (2),
    .LOCK_TIMEOUT   (32),
    .N_OUT          (4)
  ) dut (
    .clk_in1 (clk),
    .rst     (rst),
    .pll_if  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected domain_rst k cycles after pll_locked rises while in WAIT_LOCK:
  // 2 sync + 1 entry + 8 stable cycles, then a bit every 2 cycles.
  function automatic logic [3:0] exp_dom(input int k);
    if (k < 11)      return 4'b1111;
    else if (k < 13) return 4'b1110;
    else if (k < 15) return 4'b1100;
    else if (k < 17) return 4'b1000;
    else             return 4'b0000;
  endfunction

  task automatic bring_up(input int n, input string tag);
    bus.pll_locked = 1'b1;
    for (int k = 1; k <= n; k++) begin
      step();
      chk({tag, "_dom"},   32'(bus.domain_rst), 32'(exp_dom(k)));
      chk({tag, "_ready"}, 32'(bus.ready),      32'(k >= 18));
      chk({tag, "_pllrst"}, 32'(bus.pll_rst),   32'd0);
    end
  endtask

  // Called right after the edge that starts a PLL reset pulse.
  task automatic pll_rst_window(input string tag);
    chk({tag, "_pllrst_hi"}, 32'(bus.pll_rst), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_pllrst_hi"}, 32'(bus.pll_rst), 32'd1);
    end
    step();
    chk({tag, "_pllrst_lo"}, 32'(bus.pll_rst), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pllrst"},  32'(bus.pll_rst),     32'd1);
    chk({tag, "_dom"},     32'(bus.domain_rst),  32'hF);
    chk({tag, "_ready"},   32'(bus.ready),       32'd0);
    chk({tag, "_relock"},  32'(bus.relock_cnt),  32'd0);
    chk({tag, "_timeout"}, 32'(bus.timeout_err), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.pll_locked = 1'b0;

    // Reset state
    repeat (3) step();
    chk_reset_vals("reset");

    // PLL reset pulse after reset release
    rst = 1'b0;
    pll_rst_window("por");

    // Lock chatter during STABLE: count restarts, nothing released
    bus.pll_locked = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("chatter_pre_dom", 32'(bus.domain_rst), 32'hF);
    end
    bus.pll_locked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("chatter_dom",    32'(bus.domain_rst), 32'hF);
      chk("chatter_relock", 32'(bus.relock_cnt), 32'd0);
    end
    // Full nominal bring-up timeline measured from the lock re-rise
    bring_up(18, "nominal");
    chk("nominal_relock", 32'(bus.relock_cnt), 32'd0);

    // Lock loss in RUN: resets assert 3 cycles after the fall
    bus.pll_locked = 1'b0;
    step();
    step();
    chk("loss_ready_still", 32'(bus.ready),      32'd1);
    chk("loss_dom_still",   32'(bus.domain_rst), 32'h0);
    step();
    chk("loss_dom",    32'(bus.domain_rst), 32'hF);
    chk("loss_ready",  32'(bus.ready),      32'd0);
    chk("loss_relock", 32'(bus.relock_cnt), 32'd1);
    pll_rst_window("loss");
    bring_up(18, "rebring");
    chk("rebring_relock", 32'(bus.relock_cnt), 32'd1);

    // RST in mid-RELEASE at 1100
    bus.pll_locked = 1'b0;
    step();
    step();
    step();
    pll_rst_window("pre_rst");
    bring_up(13, "midrel");
    rst = 1'b1;
    step();
    chk_reset_vals("midrel_rst");
    rst = 1'b0;
    pll_rst_window("midrel_restart");
    repeat (8) step();
    chk("restart_dom_hold", 32'(bus.domain_rst), 32'hF);
    step();
    chk("restart_dom_rel0", 32'(bus.domain_rst), 32'hE);

    // Relock counter saturation over 260 lock losses
    for (int i = 1; i <= 260; i++) begin
      bus.pll_locked = 1'b0;
      repeat (8) step();
      if (i == 1 || i == 254 || i == 255 || i == 260)
        chk("sat_relock", 32'(bus.relock_cnt), (i > 255) ? 32'd255 : 32'(i));
      bus.pll_locked = 1'b1;
      repeat (12) step();
    end
    chk("sat_final_relock", 32'(bus.relock_cnt), 32'd255);
    chk("sat_final_dom",    32'(bus.domain_rst), 32'hE);

    // Watchdog behaviour with the lock held low
    bus.pll_locked = 1'b0;
    rst = 1'b1;
    step();
    chk_reset_vals("wd_rst");
    rst = 1'b0;
    pll_rst_window("wd_por");
`ifdef PLL_SEQ_WATCHDOG_EN
    repeat (31) step();
    chk("wd_before_err",    32'(bus.timeout_err), 32'd0);
    chk("wd_before_pllrst", 32'(bus.pll_rst),     32'd0);
    step();
    chk("wd_err", 32'(bus.timeout_err), 32'd1);
    pll_rst_window("wd_pulse");
    bring_up(18, "wd_lock");
    chk("wd_err_sticky", 32'(bus.timeout_err), 32'd1);
`else
    repeat (40) step();
    chk("nowd_err",    32'(bus.timeout_err), 32'd0);
    chk("nowd_pllrst", 32'(bus.pll_rst),     32'd0);
    chk("nowd_dom",    32'(bus.domain_rst),  32'hF);
    bring_up(18, "nowd_lock");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
